// File: rtl/aes256_pkg.sv
// rtl/aes256_pkg.sv - AES-256 constants, S-box table and round/key-expansion helper functions.
package aes256_pkg;

   localparam int NR      = 14;
   localparam int LATENCY = 29;

   // FIPS-197 S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

   // Only even rounds >= 2 consume an Rcon value.
   function automatic logic [7:0] rcon(input int r);
      logic [7:0] rc;
      case (r)
         2:       rc = 8'h01;
         4:       rc = 8'h02;
         6:       rc = 8'h04;
         8:       rc = 8'h08;
         10:      rc = 8'h10;
         12:      rc = 8'h20;
         14:      rc = 8'h40;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[i*8 +: 8] = sbox(s[i*8 +: 8]);
      end
      return o;
   endfunction

   // Byte n of the block lives at bits [127-8n -: 8]; row r shifts left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      return {s[127:120], s[87:80],   s[47:40],   s[7:0],
              s[95:88],   s[55:48],   s[15:8],    s[103:96],
              s[63:56],   s[23:16],   s[111:104], s[71:64],
              s[31:24],   s[119:112], s[79:72],   s[39:32]};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_column(s[127:96]), mix_column(s[95:64]),
              mix_column(s[63:32]),  mix_column(s[31:0])};
   endfunction

   // Slides the 8-word window forward by four words of the AES-256 key schedule.
   function automatic logic [255:0] key_step(input logic [255:0] win,
                                             input logic       sub_only,
                                             input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t = win[31:0];
      if (!sub_only) begin
         t = {t[23:0], t[31:24]};
      end
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
      n0 = win[255:224] ^ t;
      n1 = win[223:192] ^ n0;
      n2 = win[191:160] ^ n1;
      n3 = win[159:128] ^ n2;
      return {win[127:0], n0, n1, n2, n3};
   endfunction

endpackage

// File: rtl/aes256_round.sv
// rtl/aes256_round.sv - one AES-256 round as two register stages, carrying its key window along.
// Stage A: SubBytes+ShiftRows and key expansion; stage B: MixColumns (not in FINAL) + AddRoundKey.
module aes256_round
   import aes256_pkg::*;
#(
   parameter int ROUND = 1,
   parameter bit FINAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] s_i,
   input  logic [255:0] k_i,
   output logic [127:0] s_o,
   output logic [255:0] k_o
);

   logic [127:0] sa_d, sa_q, sb_d, sb_q;
   logic [255:0] ka_d, ka_q, kb_d, kb_q;
   logic [127:0] mixed;

   // Round 1 uses words 4..7, already present in the incoming window.
   always_comb begin
      sa_d = shift_rows(sub_bytes(s_i));
      ka_d = k_i;
      if (ROUND != 1) begin
         ka_d = key_step(k_i, ROUND % 2 == 1, rcon(ROUND));
      end
   end

   always_comb begin
      mixed = FINAL ? sa_q : mix_columns(sa_q);
      sb_d  = mixed ^ ka_q[127:0];
      kb_d  = ka_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q <= '0;
         ka_q <= '0;
         sb_q <= '0;
         kb_q <= '0;
      end else begin
         sa_q <= sa_d;
         ka_q <= ka_d;
         sb_q <= sb_d;
         kb_q <= kb_d;
      end
   end

   assign s_o = sb_q;
   assign k_o = kb_q;

endmodule

// File: rtl/aes256_encrypt_top.sv
// rtl/aes256_encrypt_top.sv - fully pipelined AES-256 encryptor, one block+key per clock, 29-cycle latency.
// Defining AES_VALID_EN adds in_valid/out_valid carried by a shift chain beside the datapath.
module aes256_encrypt_top
   import aes256_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] state,
   input  logic [255:0] key,
   output logic [127:0] out
`ifdef AES_VALID_EN
   ,
   input  logic         in_valid,
   output logic         out_valid
`endif
);

   logic [127:0] s0_d, s0_q, out_d, out_q;
   logic [255:0] k0_d, k0_q;
   logic [127:0] s_pipe [NR+1];
   logic [255:0] k_pipe [NR+1];

   always_comb begin
      s0_d  = state ^ key[255:128];
      k0_d  = key;
      out_d = s_pipe[NR];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q  <= '0;
         k0_q  <= '0;
         out_q <= '0;
      end else begin
         s0_q  <= s0_d;
         k0_q  <= k0_d;
         out_q <= out_d;
      end
   end

   assign s_pipe[0] = s0_q;
   assign k_pipe[0] = k0_q;

   for (genvar r = 1; r <= NR; r++) begin : g_round
      aes256_round #(
         .ROUND (r),
         .FINAL (r == NR)
      ) u_round (
         .clk   (clk),
         .rst_n (rst_n),
         .s_i   (s_pipe[r-1]),
         .k_i   (k_pipe[r-1]),
         .s_o   (s_pipe[r]),
         .k_o   (k_pipe[r])
      );
   end

   assign out = out_q;

`ifdef AES_VALID_EN
   // Bit LATENCY lines up with out_q: the stage-0 register plus 28 round stages plus out_q.
   logic [LATENCY:0] vld_d, vld_q;

   always_comb begin
      vld_d = {vld_q[LATENCY-1:0], in_valid};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign out_valid = vld_q[LATENCY];
`endif

endmodule

// File: tb/tb_aes256_encrypt_top.sv
// tb/tb_aes256_encrypt_top.sv - directed-vector bench for aes256_encrypt_top (optionally with AES_VALID_EN).
module tb_aes256_encrypt_top;

   logic         clk;
   logic         rst_n;
   logic [127:0] state_i;
   logic [255:0] key_i;
   logic [127:0] out_o;
`ifdef AES_VALID_EN
   logic         in_valid;
   logic         out_valid;
`endif

   int checks = 0;
   int errors = 0;

   logic [127:0] pt_tab [7] = '{
      128'h00112233445566778899aabbccddeeff,
      128'h3243f6a8885a308d313198a2e0370734,
      128'h7e4c7e6a48b32551943a5384909931fb,
      128'h6bc1bee22e409f96e93d7e117393172a,
      128'hae2d8a571e03ac9c9eb76fac45af8e51,
      128'h30c81c46a35ce411e5fbc1191a0a52ef,
      128'hf69f2445df4f9b17ad2b417be66c3710
   };
   logic [255:0] key_tab [7] = '{
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe,
      256'hee445732e5e9bc9bf508cf25535ee2e9b2d2aa6054fa85d0d4e835d898648266,
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
   };
   logic [127:0] ct_tab [7] = '{
      128'h8ea2b7ca516745bfeafc49904b496089,
      128'h1a6e6c2c662e7da6501ffb62bc9e93f3,
      128'h6ac83d115d0102158a6de49df3cf5de0,
      128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
      128'h591ccb10d410ed26dc5ba74a31362870,
      128'hb6ed21b99ca6f4f9f153e7b1beafed1d,
      128'h23304b7a39f9f3ff067d8d8f9e24ecc7
   };

   aes256_encrypt_top dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state_i),
      .key       (key_i),
      .out       (out_o)
`ifdef AES_VALID_EN
      ,
      .in_valid  (in_valid),
      .out_valid (out_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs driven at negedge k are sampled at the next posedge; the result is visible at negedge k+30.
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (out_o !== 128'h0) begin
         errors++;
         $display("FAIL reset_out: got %h expected 0", out_o);
      end
`ifdef AES_VALID_EN
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_fips();
      for (int k = 0; k <= 31; k++) begin
         @(negedge clk);
         if (k == 29) begin
            checks++;
            if (out_o === ct_tab[0]) begin
               errors++;
               $display("FAIL fips_early: got %h one cycle before latency", out_o);
            end
         end
         if (k == 30) begin
            checks++;
            if (out_o !== ct_tab[0]) begin
               errors++;
               $display("FAIL fips_latency: got %h expected %h", out_o, ct_tab[0]);
            end
         end
         if (k == 31) begin
            checks++;
            if (out_o === ct_tab[0]) begin
               errors++;
               $display("FAIL fips_hold: got %h, block repeated past its slot", out_o);
            end
         end
         state_i = (k == 0) ? pt_tab[0] : 128'h0;
         key_i   = (k == 0) ? key_tab[0] : 256'h0;
      end
   endtask

   task automatic test_stream(input string name, input int n, input int stride);
      int idx;
      for (int k = 0; k <= n + 29; k++) begin
         @(negedge clk);
         if (k >= 30) begin
            idx = ((k - 30) * stride) % 7;
            checks++;
            if (out_o !== ct_tab[idx]) begin
               errors++;
               $display("FAIL %s[%0d]: got %h expected %h", name, k - 30, out_o, ct_tab[idx]);
            end
         end
         if (k < n) begin
            state_i = pt_tab[(k * stride) % 7];
            key_i   = key_tab[(k * stride) % 7];
         end else begin
            state_i = 128'h0;
            key_i   = 256'h0;
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         state_i = pt_tab[k % 7];
         key_i   = key_tab[k % 7];
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_o !== 128'h0) begin
         errors++;
         $display("FAIL mid_reset_async: got %h expected 0", out_o);
      end
`ifdef AES_VALID_EN
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid);
      end
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_stream("after_reset", 3, 2);
   endtask

`ifdef AES_VALID_EN
   task automatic test_valid();
      for (int k = 0; k <= 31; k++) begin
         @(negedge clk);
         if (k == 29 || k == 31) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL valid_off[%0d]: got %b expected 0", k, out_valid);
            end
         end
         if (k == 30) begin
            checks++;
            if (out_valid !== 1'b1) begin
               errors++;
               $display("FAIL valid_pulse: got %b expected 1", out_valid);
            end
            checks++;
            if (out_o !== ct_tab[1]) begin
               errors++;
               $display("FAIL valid_data: got %h expected %h", out_o, ct_tab[1]);
            end
         end
         in_valid = (k == 0);
         state_i  = (k == 0) ? pt_tab[1] : 128'h0;
         key_i    = (k == 0) ? key_tab[1] : 256'h0;
      end
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      state_i = 128'h0;
      key_i   = 256'h0;
`ifdef AES_VALID_EN
      in_valid = 1'b0;
`endif
      test_reset();
      test_fips();
      test_stream("back_to_back", 7, 1);
      test_stream("long_run", 210, 3);
      test_mid_reset();
`ifdef AES_VALID_EN
      test_valid();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
